mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips32_pkg.sv | 23 ++
 rtl/mem_port_prio.sv | 37 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared encodings and defaults for the MIPS32 memory-port arbiter.
package mips32_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_prio.sv
// Fetch/data priority pick with a saturating starvation counter that
// lets fetch win once it has been denied STARVE_MAX cycles in a row.
module mem_port_prio #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk1,
  input  logic rst,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  output logic i_win,
  output logic d_win
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  always_comb begin
    starved = (starve_q == STARVE_LIM);
    d_win   = en & d_req & ~(i_req & starved);
    i_win   = en & i_req & ~d_win;
    // A denial only counts while fetch is actually asking.
    if (i_req && !i_win)
      starve_d = starved ? starve_q : starve_q + CW'(1);
    else
      starve_d = '0;
  end

  always_ff @(posedge clk1) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access,
// with one-cycle read return and a RUN/DRAIN/HALT shutdown sequence.
module mem_port_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt_req,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              halted_q, halted_d;
  logic [15:0]       conflict_q, conflict_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_en;
  logic              i_win, d_win;

  assign grant_en = ~rst & (state_q == ST_RUN) & ~halt_req;

  mem_port_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk1  (clk1),
    .rst   (rst),
    .en    (grant_en),
    .i_req (i_req),
    .d_req (d_req),
    .i_win (i_win),
    .d_win (d_win)
  );

  always_comb begin
    i_gnt     = i_win;
    d_gnt     = d_win;
    mem_en    = i_win | d_win;
    mem_we    = d_win & d_we;
    mem_addr  = d_win ? d_addr : i_addr;
    mem_wdata = d_wdata;

    // A read issued last cycle is returned now unless reset discards it.
    i_rvalid  = ~rst & (owner_q == OWN_IF);
    d_rvalid  = ~rst & (owner_q == OWN_DATA);
    i_rdata_d = rst ? '0 : (i_rvalid ? mem_rdata : i_rdata_q);
    d_rdata_d = rst ? '0 : (d_rvalid ? mem_rdata : d_rdata_q);
    i_rdata   = i_rdata_d;
    d_rdata   = d_rdata_d;

    if (i_win)               owner_d = OWN_IF;
    else if (d_win && !d_we) owner_d = OWN_DATA;
    else                     owner_d = OWN_NONE;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (halt_req) state_d = (owner_q != OWN_NONE) ? ST_DRAIN : ST_HALT;
      ST_DRAIN: state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_HALT;
    endcase

    conflict_d = (state_q == ST_RUN && i_req && d_req) ? sat_inc16(conflict_q) : conflict_q;
    halted_d   = (state_d == ST_HALT);

    halted       = halted_q;
    conflict_cnt = conflict_q;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= ST_RUN;
      owner_q    <= OWN_NONE;
      halted_q   <= 1'b0;
      conflict_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      halted_q   <= halted_d;
      conflict_q <= conflict_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a cycle-level
// behavioural model of the arbitration rules and a shadow memory.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SM = 3;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt_req = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, halted, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   conflict_cnt;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk1(clk1), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .halt_req(halt_req), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  logic [DW-1:0] hmem [2**AW];
  logic [DW-1:0] smem [2**AW];

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) hmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= hmem[mem_addr];
    end
  end

  int n_vec = 0, n_miss = 0;

  // model state: 0 run, 1 drain, 2 halt
  int            m_state = 0, m_starve = 0, m_conf = 0;
  bit            m_pi = 0, m_pd = 0;
  logic [DW-1:0] m_pdata = '0, m_li = '0, m_ld = '0;
  bit            last_gi, last_gd;
  logic          s_ignt, s_dgnt, s_irv, s_drv, s_halted, s_memen;
  logic [DW-1:0] s_ird, s_drd;
  logic [15:0]   s_conf;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia,
                      input bit dr, input bit dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd, input bit h);
    bit gi, gd, en;
    logic [DW-1:0] ei, ed;
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da;
    d_wdata = dwd; halt_req = h;
    @(negedge clk1);
    gi = 0; gd = 0;
    if (!r) begin
      en = (m_state == 0) && !h;
      gd = en && dr && !(ir && m_starve == SM);
      gi = en && ir && !gd;
    end
    s_ignt = i_gnt; s_dgnt = d_gnt; s_irv = i_rvalid; s_drv = d_rvalid;
    s_ird = i_rdata; s_drd = d_rdata; s_halted = halted; s_conf = conflict_cnt;
    s_memen = mem_en;
    chk("i_gnt", i_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    chk("mem_en", mem_en, gi | gd);
    if (gd) begin
      chk("mem_addr_d", mem_addr, da);
      chk("mem_we_d", mem_we, dw);
      if (dw) chk("mem_wdata", mem_wdata, dwd);
    end else if (gi) begin
      chk("mem_addr_i", mem_addr, ia);
      chk("mem_we_i", mem_we, 0);
    end
    chk("i_rvalid", i_rvalid, !r && m_pi);
    chk("d_rvalid", d_rvalid, !r && m_pd);
    ei = r ? '0 : (m_pi ? m_pdata : m_li);
    ed = r ? '0 : (m_pd ? m_pdata : m_ld);
    chk("i_rdata", i_rdata, ei);
    chk("d_rdata", d_rdata, ed);
    if (!r) begin
      chk("halted", halted, m_state == 2);
      chk("conflict_cnt", conflict_cnt, m_conf);
    end
    last_gi = gi; last_gd = gd;
    @(posedge clk1);
    if (r) begin
      m_state = 0; m_starve = 0; m_pi = 0; m_pd = 0; m_li = '0; m_ld = '0; m_conf = 0;
    end else begin
      if (m_pi) m_li = m_pdata;
      if (m_pd) m_ld = m_pdata;
      if (m_state == 0 && ir && dr && m_conf < 65535) m_conf++;
      m_starve = (ir && !gi) ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      if (m_state == 0 && h) m_state = (m_pi || m_pd) ? 1 : 2;
      else if (m_state == 1) m_state = 2;
      m_pi = gi;
      m_pd = gd && !dw;
      if (gi) m_pdata = smem[ia];
      else if (gd && !dw) m_pdata = smem[da];
      if (gd && dw) smem[da] = dwd;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, '0, '0, 0);
    step(1, 0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seq [8];
    bit pi, pd, pdw;
    logic [AW-1:0] pia, pda;
    logic [DW-1:0] pdd;
    seq = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int k = 0; k < 2**AW; k++) begin
      hmem[k] = $urandom;
      smem[k] = hmem[k];
    end
    hmem[5] = 32'h2801000a;
    smem[5] = 32'h2801000a;

    do_reset();
    idle();
    chk("rst_conflict", s_conf, 16'h0);
    chk("rst_halted", s_halted, 1'b0);
    chk("rst_irdata", s_ird, 32'h0);

    // single fetch
    step(0, 1, 11'd5, 0, 0, '0, '0, 0);
    chk("fetch_gnt", s_ignt, 1'b1);
    idle();
    chk("fetch_rvalid", s_irv, 1'b1);
    chk("fetch_rdata", s_ird, 32'h2801000a);

    // sustained conflict: D,D,D,I pattern
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 11'd7, 1, 0, 11'd100, '0, 0);
      chk($sformatf("starve_seq_d%0d", k), s_dgnt, seq[k]);
      chk($sformatf("starve_seq_i%0d", k), s_ignt, !seq[k]);
    end
    idle();
    chk("conflict_8", s_conf, 16'd8);

    // store then load to the same address
    step(0, 0, '0, 1, 1, 11'd20, 32'h1E, 0);
    step(0, 0, '0, 1, 0, 11'd20, '0, 0);
    chk("store_no_rvalid", s_drv, 1'b0);
    idle();
    chk("load_rvalid", s_drv, 1'b1);
    chk("load_rdata", s_drd, 32'h1E);

    // randomized traffic obeying the hold-until-grant protocol
    pi = 0; pd = 0; pdw = 0; pia = '0; pda = '0; pdd = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!pi && $urandom_range(0, 99) < 60) begin
        pi = 1; pia = AW'($urandom_range(16, 47));
      end
      if (!pd && $urandom_range(0, 99) < 50) begin
        pd = 1; pdw = $urandom_range(0, 1) != 0;
        pda = AW'($urandom_range(16, 47)); pdd = $urandom;
      end
      step(0, pi, pia, pd, pdw, pda, pdd, 0);
      if (last_gi) pi = 0;
      if (last_gd) pd = 0;
    end
    idle();

    // reset discards an outstanding load
    step(0, 0, '0, 1, 0, 11'd100, '0, 0);
    chk("pre_rst_dgnt", s_dgnt, 1'b1);
    step(1, 0, '0, 0, 0, '0, '0, 0);
    chk("rst_cycle_drvalid", s_drv, 1'b0);
    idle();
    chk("post_rst_drvalid", s_drv, 1'b0);
    chk("post_rst_drdata", s_drd, 32'h0);
    chk("post_rst_conflict", s_conf, 16'h0);

    // conflict counter saturation
    for (int n = 0; n < 65538; n++) step(0, 1, 11'd30, 1, 0, 11'd31, '0, 0);
    idle();
    chk("conflict_sat", s_conf, 16'hFFFF);

    // halt right after a fetch grant
    do_reset();
    step(0, 1, 11'd5, 0, 0, '0, '0, 0);
    chk("halt_pre_gnt", s_ignt, 1'b1);
    step(0, 1, 11'd6, 1, 0, 11'd9, '0, 1);
    chk("halt_cycle_gnt", s_ignt | s_dgnt, 1'b0);
    chk("halt_cycle_rvalid", s_irv, 1'b1);
    chk("halt_cycle_rdata", s_ird, 32'h2801000a);
    step(0, 1, 11'd6, 1, 0, 11'd9, '0, 0);
    chk("drain_halted", s_halted, 1'b0);
    chk("drain_memen", s_memen, 1'b0);
    for (int n = 0; n < 10; n++) begin
      step(0, 1, 11'd6, 1, 1, 11'd9, 32'h55, 0);
      chk($sformatf("halt_memen%0d", n), s_memen, 1'b0);
      chk($sformatf("halt_halted%0d", n), s_halted, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
